// File: rtl/qdma_h2c_axis_adapter.sv
// ============================================================================
// Module   : qdma_h2c_axis_adapter
// Purpose  : Bridges the QDMA H2C stream (mty-encoded, per-beat sideband)
//            onto a plain AXI4-Stream with tkeep. Latches qid/port per packet,
//            truncates errored or oversized packets, discards zero-byte
//            packets, counts forwarded and dropped packets, and registers the
//            output through a 2-entry skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qdma_h2c_axis_adapter #(
    parameter int DATA_WIDTH    = 512,
    parameter int QID_WIDTH     = 11,
    parameter int MAX_PKT_BEATS = 32
) (
    input  logic                      axis_aclk,
    input  logic                      aresetn,
    // QDMA H2C stream
    input  logic [DATA_WIDTH-1:0]     s_axis_h2c_tdata,
    input  logic                      s_axis_h2c_tvalid,
    output logic                      s_axis_h2c_tready,
    input  logic                      s_axis_h2c_tlast,
    input  logic [5:0]                s_axis_h2c_tuser_mty,
    input  logic                      s_axis_h2c_tuser_err,
    input  logic                      s_axis_h2c_tuser_zero_byte,
    input  logic [QID_WIDTH-1:0]      s_axis_h2c_tuser_qid,
    input  logic [2:0]                s_axis_h2c_tuser_port_id,
    // Pipeline AXI4-Stream
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [QID_WIDTH-1:0]      m_axis_tuser_qid,
    output logic [2:0]                m_axis_tuser_port_id,
    output logic                      m_axis_tuser_err,
    // Statistics
    output logic [31:0]               pkt_cnt,
    output logic [31:0]               drop_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_keep_w   = DATA_WIDTH / 8;
    // Skid entry layout, LSB first: err, port[2:0], qid, last, keep, data
    localparam int c_port_lsb = 1;
    localparam int c_qid_lsb  = 4;
    localparam int c_last_bit = 4 + QID_WIDTH;
    localparam int c_keep_lsb = 5 + QID_WIDTH;
    localparam int c_data_lsb = c_keep_lsb + c_keep_w;
    localparam int c_ent_w    = c_data_lsb + DATA_WIDTH;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_in_pkt = 2'd1;
    localparam logic [1:0] c_st_drop   = 2'd2;

    // Beat index at which a still-open packet is force-terminated
    localparam logic [7:0]          c_last_beat = 8'(MAX_PKT_BEATS - 1);
    localparam logic [c_keep_w-1:0] c_keep_ones = '1;
    localparam logic [31:0]         c_cnt_max   = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [7:0]           r_beats;
    logic [QID_WIDTH-1:0] r_qid;
    logic [2:0]           r_port;
    logic [31:0]          r_pkt_cnt;
    logic [31:0]          r_drop_cnt;
    logic                 r_tready;
    logic [1:0]           r_count;
    logic [c_ent_w-1:0]   r_slot0;
    logic [c_ent_w-1:0]   r_slot1;

    // ------------------------------------------------------------------------
    // Combinational classification of the current input beat
    // ------------------------------------------------------------------------
    logic                 w_accept;
    logic                 w_fwd;
    logic                 w_force_last;
    logic                 w_pkt_inc;
    logic                 w_drop_inc;
    logic                 w_use_in_side;
    logic [1:0]           w_nstate;
    logic [7:0]           w_nbeats;
    logic [c_keep_w-1:0]  w_keep;
    logic [QID_WIDTH-1:0] w_qid;
    logic [2:0]           w_port;
    logic [c_ent_w-1:0]   w_in_entry;
    logic                 w_push;
    logic                 w_pop;
    logic [1:0]           w_count_next;

    assign w_accept = s_axis_h2c_tvalid & r_tready;

    // Decide per accepted beat: forward or not, forced termination, counter bumps, next state
    always_comb begin
        w_fwd         = 1'b0;
        w_force_last  = 1'b0;
        w_pkt_inc     = 1'b0;
        w_drop_inc    = 1'b0;
        w_use_in_side = 1'b0;
        w_nstate      = r_state;
        w_nbeats      = r_beats;
        if (w_accept) begin
            case (r_state)
                c_st_idle: begin
                    if (s_axis_h2c_tuser_zero_byte) begin
                        w_drop_inc = 1'b1;
                        w_nstate   = s_axis_h2c_tlast ? c_st_idle : c_st_drop;
                    end else if (s_axis_h2c_tuser_err) begin
                        w_fwd         = 1'b1;
                        w_force_last  = 1'b1;
                        w_drop_inc    = 1'b1;
                        w_use_in_side = 1'b1;
                        w_nstate      = s_axis_h2c_tlast ? c_st_idle : c_st_drop;
                    end else if (s_axis_h2c_tlast) begin
                        w_fwd         = 1'b1;
                        w_pkt_inc     = 1'b1;
                        w_use_in_side = 1'b1;
                    end else begin
                        w_fwd         = 1'b1;
                        w_use_in_side = 1'b1;
                        w_nbeats      = 8'd1;
                        w_nstate      = c_st_in_pkt;
                    end
                end
                c_st_in_pkt: begin
                    if (s_axis_h2c_tuser_err ||
                        ((r_beats == c_last_beat) && !s_axis_h2c_tlast)) begin
                        w_fwd        = 1'b1;
                        w_force_last = 1'b1;
                        w_drop_inc   = 1'b1;
                        w_nbeats     = 8'd0;
                        w_nstate     = s_axis_h2c_tlast ? c_st_idle : c_st_drop;
                    end else if (s_axis_h2c_tlast) begin
                        w_fwd     = 1'b1;
                        w_pkt_inc = 1'b1;
                        w_nbeats  = 8'd0;
                        w_nstate  = c_st_idle;
                    end else begin
                        w_fwd    = 1'b1;
                        w_nbeats = r_beats + 8'd1;
                    end
                end
                c_st_drop: begin
                    if (s_axis_h2c_tlast) begin
                        w_nstate = c_st_idle;
                    end
                end
                default: begin
                    w_nstate = c_st_idle;
                    w_nbeats = 8'd0;
                end
            endcase
        end
    end

    // mty only trims a genuine input last beat; forced-last beats stay full width
    assign w_keep = s_axis_h2c_tlast ? (c_keep_ones >> s_axis_h2c_tuser_mty) : c_keep_ones;
    // A packet's first beat carries its own sideband; later beats reuse the latched copy
    assign w_qid  = w_use_in_side ? s_axis_h2c_tuser_qid     : r_qid;
    assign w_port = w_use_in_side ? s_axis_h2c_tuser_port_id : r_port;

    assign w_in_entry = {s_axis_h2c_tdata, w_keep, (s_axis_h2c_tlast | w_force_last),
                         w_qid, w_port, w_force_last};

    assign w_push       = w_fwd;
    assign w_pop        = (r_count != 2'd0) & m_axis_tready;
    assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

    // Packet FSM, beat counter and per-packet sideband latch
    always_ff @(posedge axis_aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= c_st_idle;
            r_beats <= 8'd0;
            r_qid   <= '0;
            r_port  <= 3'd0;
        end else begin
            r_state <= w_nstate;
            r_beats <= w_nbeats;
            if (w_use_in_side) begin
                r_qid  <= s_axis_h2c_tuser_qid;
                r_port <= s_axis_h2c_tuser_port_id;
            end
        end
    end

    // Saturating packet and drop counters
    always_ff @(posedge axis_aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pkt_cnt  <= 32'd0;
            r_drop_cnt <= 32'd0;
        end else begin
            if (w_pkt_inc && (r_pkt_cnt != c_cnt_max)) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            if (w_drop_inc && (r_drop_cnt != c_cnt_max)) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
        end
    end

    // Two-entry skid buffer; slot0 is the head presented on the output.
    // Input ready is registered from the next occupancy, so m_axis_tready
    // never reaches s_axis_h2c_tready combinationally.
    always_ff @(posedge axis_aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_slot0  <= '0;
            r_slot1  <= '0;
            r_count  <= 2'd0;
            r_tready <= 1'b0;
        end else begin
            if (w_push && w_pop) begin
                if (r_count == 2'd2) begin
                    r_slot0 <= r_slot1;
                    r_slot1 <= w_in_entry;
                end else begin
                    r_slot0 <= w_in_entry;
                end
            end else if (w_push) begin
                if (r_count == 2'd0) begin
                    r_slot0 <= w_in_entry;
                end else begin
                    r_slot1 <= w_in_entry;
                end
            end else if (w_pop) begin
                r_slot0 <= r_slot1;
            end
            r_count  <= w_count_next;
            r_tready <= (w_count_next < 2'd2);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign s_axis_h2c_tready    = r_tready;
    assign m_axis_tvalid        = (r_count != 2'd0);
    assign m_axis_tdata         = r_slot0[c_data_lsb +: DATA_WIDTH];
    assign m_axis_tkeep         = r_slot0[c_keep_lsb +: c_keep_w];
    assign m_axis_tlast         = r_slot0[c_last_bit];
    assign m_axis_tuser_qid     = r_slot0[c_qid_lsb +: QID_WIDTH];
    assign m_axis_tuser_port_id = r_slot0[c_port_lsb +: 3];
    assign m_axis_tuser_err     = r_slot0[0];
    assign pkt_cnt              = r_pkt_cnt;
    assign drop_cnt             = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_qdma_h2c_axis_adapter.sv
// ============================================================================
// Module   : tb_qdma_h2c_axis_adapter
// Purpose  : Directed self-checking bench for qdma_h2c_axis_adapter. A second
//            instance with MAX_PKT_BEATS=4 covers oversize truncation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qdma_h2c_axis_adapter;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        logic [10:0]  qid;
        logic [2:0]   port;
        logic         err;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [511:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic [5:0]   in_mty;
    logic         in_err;
    logic         in_zb;
    logic [10:0]  in_qid;
    logic [2:0]   in_port;
    logic         sel4;
    logic         m_tready;

    logic         v0, v4;
    logic         s_tready, s_tready4;
    logic [511:0] m_data, m_data4;
    logic [63:0]  m_keep, m_keep4;
    logic         m_valid, m_valid4;
    logic         m_last, m_last4;
    logic [10:0]  m_qid, m_qid4;
    logic [2:0]   m_port, m_port4;
    logic         m_err, m_err4;
    logic [31:0]  pkt_cnt, pkt_cnt4;
    logic [31:0]  drop_cnt, drop_cnt4;

    int    checks   = 0;
    int    failures = 0;
    beat_t q[$];
    beat_t q4[$];
    bit    occ_en   = 1'b0;
    int    occ      = 0;
    int    occ_viol = 0;
    bit    saw_full = 1'b0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    assign v0 = in_valid & ~sel4;
    assign v4 = in_valid & sel4;

    always #5 clk = ~clk;

    qdma_h2c_axis_adapter dut (
        .axis_aclk                  (clk),
        .aresetn                    (rst_n),
        .s_axis_h2c_tdata           (in_data),
        .s_axis_h2c_tvalid          (v0),
        .s_axis_h2c_tready          (s_tready),
        .s_axis_h2c_tlast           (in_last),
        .s_axis_h2c_tuser_mty       (in_mty),
        .s_axis_h2c_tuser_err       (in_err),
        .s_axis_h2c_tuser_zero_byte (in_zb),
        .s_axis_h2c_tuser_qid       (in_qid),
        .s_axis_h2c_tuser_port_id   (in_port),
        .m_axis_tdata               (m_data),
        .m_axis_tkeep               (m_keep),
        .m_axis_tvalid              (m_valid),
        .m_axis_tready              (m_tready),
        .m_axis_tlast               (m_last),
        .m_axis_tuser_qid           (m_qid),
        .m_axis_tuser_port_id       (m_port),
        .m_axis_tuser_err           (m_err),
        .pkt_cnt                    (pkt_cnt),
        .drop_cnt                   (drop_cnt)
    );

    qdma_h2c_axis_adapter #(.MAX_PKT_BEATS(4)) dut4 (
        .axis_aclk                  (clk),
        .aresetn                    (rst_n),
        .s_axis_h2c_tdata           (in_data),
        .s_axis_h2c_tvalid          (v4),
        .s_axis_h2c_tready          (s_tready4),
        .s_axis_h2c_tlast           (in_last),
        .s_axis_h2c_tuser_mty       (in_mty),
        .s_axis_h2c_tuser_err       (in_err),
        .s_axis_h2c_tuser_zero_byte (in_zb),
        .s_axis_h2c_tuser_qid       (in_qid),
        .s_axis_h2c_tuser_port_id   (in_port),
        .m_axis_tdata               (m_data4),
        .m_axis_tkeep               (m_keep4),
        .m_axis_tvalid              (m_valid4),
        .m_axis_tready              (m_tready),
        .m_axis_tlast               (m_last4),
        .m_axis_tuser_qid           (m_qid4),
        .m_axis_tuser_port_id       (m_port4),
        .m_axis_tuser_err           (m_err4),
        .pkt_cnt                    (pkt_cnt4),
        .drop_cnt                   (drop_cnt4)
    );

    // Record output transfers and track buffer occupancy away from the active edge
    always @(negedge clk) begin
        if (m_valid && m_tready) q.push_back('{m_data, m_keep, m_last, m_qid, m_port, m_err});
        if (m_valid4 && m_tready) q4.push_back('{m_data4, m_keep4, m_last4, m_qid4, m_port4, m_err4});
        if (occ_en) begin
            if (s_tready !== (occ < 2)) occ_viol++;
            if (!s_tready) saw_full = 1'b1;
            occ = occ + ((v0 && s_tready) ? 1 : 0) - ((m_valid && m_tready) ? 1 : 0);
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [63:0] tag, input logic last, input logic [5:0] mty,
                        input logic err, input logic zb, input logic [10:0] qid,
                        input logic [2:0] port);
        int t = 0;
        in_data  = {8{tag}};
        in_last  = last;
        in_mty   = mty;
        in_err   = err;
        in_zb    = zb;
        in_qid   = qid;
        in_port  = port;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (sel4 ? s_tready4 : s_tready) break;
            t++;
            if (t > 300) begin
                failures++;
                $error("FAIL send_timeout observed=stalled expected=accepted tag=%0h", tag);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_q(input int n, input bit use4);
        int t = 0;
        forever begin
            @(negedge clk);
            if ((use4 ? q4.size() : q.size()) >= n) break;
            t++;
            if (t > 400) begin
                failures++;
                $error("FAIL wait_beats observed=%0d expected=%0d", use4 ? q4.size() : q.size(), n);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] pat;
        pat      = 4'b1001;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_mty   = 6'd0;
        in_err   = 1'b0;
        in_zb    = 1'b0;
        in_qid   = 11'd0;
        in_port  = 3'd0;
        sel4     = 1'b0;
        m_tready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_m_tvalid", m_valid, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_tkeep", m_keep, 0);
        chk("rst_tlast", m_last, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("tready_after_rst", s_tready, 1);

        // Single-beat packet, latency 1, hold while not ready
        send(64'h11, 1'b1, 6'd0, 1'b0, 1'b0, 11'd2, 3'd0);
        chk("t1_valid_lat1", m_valid, 1);
        chk("t1_data", m_data, {8{64'h11}});
        chk("t1_keep", m_keep, ONES);
        chk("t1_qid", m_qid, 2);
        chk("t1_pkt_cnt", pkt_cnt, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("t1_hold_valid", m_valid, 1);
        chk("t1_hold_data", m_data, {8{64'h11}});
        m_tready = 1'b1;
        wait_q(1, 1'b0);
        chk("t1_beats", q.size(), 1);
        chk("t1_last", q[0].last, 1);

        // 3-beat packet, mty=6 on last, qid changes mid-packet
        q.delete();
        send(64'h21, 1'b0, 6'd0, 1'b0, 1'b0, 11'd5, 3'd1);
        send(64'h22, 1'b0, 6'd0, 1'b0, 1'b0, 11'd7, 3'd2);
        send(64'h23, 1'b1, 6'd6, 1'b0, 1'b0, 11'd7, 3'd2);
        wait_q(3, 1'b0);
        chk("t2_keep0", q[0].keep, ONES);
        chk("t2_keep1", q[1].keep, ONES);
        chk("t2_keep2", q[2].keep, 64'h03FF_FFFF_FFFF_FFFF);
        chk("t2_qid1", q[1].qid, 5);
        chk("t2_qid2", q[2].qid, 5);
        chk("t2_port2", q[2].port, 1);
        chk("t2_last0", q[0].last, 0);
        chk("t2_last2", q[2].last, 1);
        chk("t2_pkt_cnt", pkt_cnt, 2);

        // 8-beat packet with output ready toggling 1,0,0,1
        q.delete();
        occ = 0;
        occ_viol = 0;
        saw_full = 1'b0;
        occ_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(64'h30 + 64'(i), (i == 7), 6'd0, 1'b0, 1'b0, 11'd1, 3'd0);
            end
            begin
                for (int i = 0; i < 400 && q.size() < 8; i++) begin
                    @(posedge clk);
                    #1;
                    m_tready = pat[i % 4];
                end
            end
        join
        occ_en = 1'b0;
        m_tready = 1'b1;
        wait_q(8, 1'b0);
        chk("t3_beats", q.size(), 8);
        for (int i = 0; i < 8 && i < q.size(); i++) begin
            chk($sformatf("t3_data%0d", i), q[i].data, {8{64'h30 + 64'(i)}});
            chk($sformatf("t3_last%0d", i), q[i].last, (i == 7));
        end
        chk("t3_tready_model", occ_viol, 0);
        chk("t3_buffer_filled", saw_full, 1);
        chk("t3_pkt_cnt", pkt_cnt, 3);

        // err on beat 2 of a 5-beat packet, then a normal 2-beat packet
        q.delete();
        for (int i = 0; i < 5; i++)
            send(64'h41 + 64'(i), (i == 4), 6'd0, (i == 2), 1'b0, 11'd3, 3'd4);
        send(64'h51, 1'b0, 6'd0, 1'b0, 1'b0, 11'd6, 3'd3);
        send(64'h52, 1'b1, 6'd0, 1'b0, 1'b0, 11'd6, 3'd3);
        wait_q(5, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_beats", q.size(), 5);
        chk("t4_b1_last", q[1].last, 0);
        chk("t4_b2_data", q[2].data, {8{64'h43}});
        chk("t4_b2_last", q[2].last, 1);
        chk("t4_b2_err", q[2].err, 1);
        chk("t4_b2_port", q[2].port, 4);
        chk("t4_next_data", q[3].data, {8{64'h51}});
        chk("t4_next_qid", q[3].qid, 6);
        chk("t4_next_last", q[4].last, 1);
        chk("t4_next_err", q[4].err, 0);
        chk("t4_drop_cnt", drop_cnt, 1);
        chk("t4_pkt_cnt", pkt_cnt, 4);

        // Oversize packet on the MAX_PKT_BEATS=4 instance
        sel4 = 1'b1;
        q4.delete();
        for (int i = 0; i < 6; i++)
            send(64'h61 + 64'(i), (i == 5), 6'd0, 1'b0, 1'b0, 11'd1, 3'd0);
        sel4 = 1'b0;
        wait_q(4, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_beats", q4.size(), 4);
        chk("t5_b2_last", q4[2].last, 0);
        chk("t5_b3_data", q4[3].data, {8{64'h64}});
        chk("t5_b3_last", q4[3].last, 1);
        chk("t5_b3_err", q4[3].err, 1);
        chk("t5_b3_keep", q4[3].keep, ONES);
        chk("t5_drop_cnt", drop_cnt4, 1);
        chk("t5_pkt_cnt", pkt_cnt4, 0);
        chk("t5_other_pkt_cnt", pkt_cnt, 4);

        // Zero-byte packet, then reset in the middle of a packet
        q.delete();
        send(64'h71, 1'b1, 6'd0, 1'b0, 1'b1, 11'd2, 3'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_zb_beats", q.size(), 0);
        chk("t6_zb_drop_cnt", drop_cnt, 2);
        send(64'h81, 1'b0, 6'd0, 1'b0, 1'b0, 11'd3, 3'd2);
        send(64'h82, 1'b0, 6'd0, 1'b0, 1'b0, 11'd3, 3'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pkt_cnt", pkt_cnt, 0);
        chk("t6_rst_drop_cnt", drop_cnt, 0);
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_tready", s_tready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        send(64'h91, 1'b0, 6'd0, 1'b0, 1'b0, 11'd9, 3'd5);
        send(64'h92, 1'b1, 6'd0, 1'b0, 1'b0, 11'd4, 3'd1);
        wait_q(2, 1'b0);
        chk("t6_post_beats", q.size(), 2);
        chk("t6_post_qid0", q[0].qid, 9);
        chk("t6_post_qid1", q[1].qid, 9);
        chk("t6_post_port1", q[1].port, 5);
        chk("t6_post_last1", q[1].last, 1);
        chk("t6_post_err1", q[1].err, 0);
        chk("t6_post_pkt_cnt", pkt_cnt, 1);
        chk("t6_post_drop_cnt", drop_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/qdma_h2c_axis_adapter.md
Name: qdma_h2c_axis_adapter

Overview:
Converts the QDMA H2C stream (mty-encoded, per-beat qid/port/err/zero_byte sideband) into a standard AXI4-Stream with tkeep for the packet-filter pipeline input. It sits directly between the QDMA H2C interface and the pipeline. It latches per-packet qid/port, truncates errored or oversized packets, discards zero-byte packets, and keeps packet and drop counters. Output is registered through a 2-entry skid buffer.

Parameters:
DATA_WIDTH, 512, data bus width in bits; keep width is DATA_WIDTH/8.
QID_WIDTH, 11, queue id width.
MAX_PKT_BEATS, 32, maximum beats per packet; range 2..255.

Ports:
axis_aclk  in  1  clock.
aresetn  in  1  asynchronous active-low reset.
s_axis_h2c_tdata  in  DATA_WIDTH  input data; byte 0 is at the LSBs.
s_axis_h2c_tvalid  in  1  input valid.
s_axis_h2c_tready  out  1  input ready.
s_axis_h2c_tlast  in  1  last beat of packet.
s_axis_h2c_tuser_mty  in  6  empty bytes on the last beat.
s_axis_h2c_tuser_err  in  1  QDMA error flag for this beat.
s_axis_h2c_tuser_zero_byte  in  1  zero-length packet marker.
s_axis_h2c_tuser_qid  in  QID_WIDTH  queue id.
s_axis_h2c_tuser_port_id  in  3  port id.
m_axis_tdata  out  DATA_WIDTH  output data.
m_axis_tkeep  out  DATA_WIDTH/8  byte enables.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  output ready.
m_axis_tlast  out  1  output last.
m_axis_tuser_qid  out  QID_WIDTH  qid latched at the first beat.
m_axis_tuser_port_id  out  3  port latched at the first beat.
m_axis_tuser_err  out  1  set on the forced-last beat of a truncated packet.
pkt_cnt  out  32  packets forwarded with tlast and no err; saturating.
drop_cnt  out  32  zero-byte, errored or truncated packets; saturating.

Behaviour:
- Reset (asynchronous, aresetn=0):
  - m_axis_tvalid=0, s_axis_h2c_tready=0, both counters 0, FSM in IDLE, beat count 0, skid buffer empty.
  - All other outputs are 0.
  - s_axis_h2c_tready rises on the first clock edge after reset deasserts.
  - Reset mid-packet discards all state. The next accepted beat is treated as a packet start.
- Input handshake:
  - A beat is accepted when s_axis_h2c_tvalid & s_axis_h2c_tready.
  - s_axis_h2c_tready is registered and equals "skid buffer not full" (fewer than 2 entries).
  - No combinational path exists from m_axis_tready to s_axis_h2c_tready.
- Output handshake:
  - Standard AXIS. An accepted beat appears at the output on the next cycle if the buffer was empty (latency 1).
  - While valid, output fields are stable until m_axis_tready.
  - Full throughput of 1 beat/cycle is sustained when m_axis_tready=1.
- tkeep:
  - Non-last beat: all ones; mty is ignored.
  - Last beat: all-ones >> mty, i.e. the low (64-mty) bytes are valid.
  - mty=0 on a last beat gives all ones.
- qid/port: captured at the first beat of a packet and applied to every forwarded beat. Mid-packet sideband changes are ignored.
- FSM states: IDLE, IN_PKT, DROP. Beat count b counts beats forwarded in the current packet.
- IDLE, on an accepted beat:
  - zero_byte=1: not forwarded; drop_cnt++. If tlast, stay in IDLE; otherwise go to DROP.
  - err=1: forward the beat with tlast=1, tuser_err=1; drop_cnt++. Go to DROP unless input tlast, in which case stay in IDLE.
  - tlast=1: forward the beat; pkt_cnt++; stay in IDLE.
  - Otherwise: forward the beat; b=1; go to IN_PKT.
- IN_PKT, on an accepted beat:
  - err=1 or b==MAX_PKT_BEATS-1 with tlast=0: forward the beat with forced tlast=1, tuser_err=1; drop_cnt++. Go to DROP, or to IDLE if input tlast.
  - Else tlast=1: forward the beat; pkt_cnt++; b=0; go to IDLE.
  - Else: forward the beat; b++.
  - err and tlast together: forwarded as an errored last beat; drop_cnt++ only; go to IDLE.
- DROP:
  - Accepted beats are consumed (tready still follows the buffer) and not forwarded.
  - tlast returns the FSM to IDLE. No counter changes.
- Counters: saturate at 32'hFFFF_FFFF and never wrap. Each updates on the cycle the classifying beat is accepted.

Test Plan:
- Single beat, tlast=1, mty=0, qid=2, port=0 -> one output beat 1 cycle later; tkeep=64'hFFFF_FFFF_FFFF_FFFF; tuser_qid=2; pkt_cnt=1.
- 3-beat packet, last mty=6, qid=5 then qid changed to 7 on beat 2 -> beats 0/1 tkeep all ones; beat 2 tkeep=64'h03FF_FFFF_FFFF_FFFF; all beats tuser_qid=5.
- 8-beat packet with m_axis_tready toggling 1,0,0,1 repeating -> s_axis_h2c_tready drops only when 2 beats are buffered; all 8 beats emitted in order with no loss or duplication.
- err=1 on beat 2 of a 5-beat packet -> beats 0,1 normal; beat 2 has tlast=1, tuser_err=1; beats 3,4 dropped; drop_cnt=1, pkt_cnt unchanged; the next packet passes normally.
- MAX_PKT_BEATS=4, 6-beat packet -> 4 beats out, 4th with tlast=1, tuser_err=1; beats 5-6 dropped; drop_cnt=1.
- zero_byte=1 single beat, then aresetn pulsed low in the middle of a 3-beat packet -> nothing output for the zero-byte beat and drop_cnt=1; after reset, counters are 0, m_axis_tvalid=0, and the next beat starts a fresh packet with a new qid latched.
